rom: RTL and testbench
======================

Name: rom

Overview:
- 256 x 8-bit read-only lookup table with synchronous, registered read port.
- Holds fixed constant data (program/coefficient store) addressed by an 8-bit address.
- Single clock domain; synchronous active-high reset clears the output register.
- No write path; contents are fixed at elaboration.

Parameters:
- ADDR_W, 8, address width; fixed at 8 (256 entries); other values unsupported.
- DATA_W, 8, data width; fixed at 8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  read enable; a read is issued on a rising edge where en=1
- addr  input  8  read address, sampled on the rising clk edge when en=1
- data  output  8  registered read data
- valid  output  1  high for exactly the cycle(s) in which data holds the result of a read issued on the previous edge

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Contents, fixed:
  - ROM[0x00]=0x3C, ROM[0x01]=0xA5, ROM[0x02]=0x7E, ROM[0x03]=0xFF.
  - For every addr 0x04..0xFF: ROM[addr] = addr XOR 0x5A.
- Implementation: full 256-entry constant table (case statement or initialised constant array). No external memory file.
- Reset (rst=1 at a rising edge): data <= 0x00, valid <= 0. Reset has priority over en.
- Read latency: 1 cycle. On a rising edge with rst=0 and en=1: data <= ROM[addr], valid <= 1.
- Idle (rst=0, en=0): data holds its last value; valid <= 0.
- Back-to-back reads: en may stay high every cycle, giving full throughput of one new word per cycle.
- Address changes while en=0 have no effect on data.
- Reset mid-stream: the read issued on the same edge as rst=1 is discarded; data=0x00 and valid=0 on the next cycle.
- Address wrap: none. All 256 addresses are valid; no out-of-range condition exists.
- No combinational path from addr or en to data or valid.
- Outputs are undefined only before the first clock edge. A bench must apply rst before checking.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1 and addr=0x01 -> data=0x00, valid=0 after each edge.
- Explicit entries: en=1, addr=0x00,0x01,0x02,0x03 on consecutive edges -> data=0x3C,0xA5,0x7E,0xFF each one cycle later, with valid=1 throughout.
- Formula entries: read 0x04, 0x80, 0xFF -> data=0x5E, 0xDA, 0xA5 respectively, each with 1-cycle latency.
- Hold: read 0x03 (data=0xFF), then en=0 while addr sweeps 0x10..0x20 -> data stays 0xFF, valid=0.
- Reset mid-stream: streaming reads with rst asserted on the edge that samples addr=0x02 -> next cycle data=0x00, valid=0. Reads after rst deasserts resume with correct 1-cycle latency.
- Exhaustive sweep: addr 0x00..0xFF with en=1 every cycle -> every returned word matches the content rule, with no gaps.

Source files
------------

// File: rtl/rom.sv
// 256 x 8 constant lookup table with a registered, one-cycle-latency read port.
// Entries 0x00..0x03 are fixed constants; every other entry is addr ^ 0x5A.
module rom #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              valid
);

    logic [DATA_W-1:0] rom_word;

    // Table decode; only the first four words break the xor pattern.
    always_comb begin
        rom_word = addr ^ 8'h5A;
        case (addr)
            8'h00:   rom_word = 8'h3C;
            8'h01:   rom_word = 8'hA5;
            8'h02:   rom_word = 8'h7E;
            8'h03:   rom_word = 8'hFF;
            default: rom_word = addr ^ 8'h5A;
        endcase
    end

    // Reset wins over a read issued on the same edge; idle cycles keep data.
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (en) begin
            data  <= rom_word;
            valid <= 1'b1;
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rom.sv
// Self-checking bench for rom: vector table plus hold, mid-stream reset and
// exhaustive sweep sequences, all checked through an expected-result queue.
module tb_rom;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] addr;
    logic [7:0] data;
    logic       valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       r;
        logic       e;
        logic [7:0] a;
        logic [7:0] exp_d;
        logic       exp_v;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       v;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[11];

    rom #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .addr  (addr),
        .data  (data),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_rom(input logic [7:0] a);
        if (a == 8'h00) return 8'h3C;
        if (a == 8'h01) return 8'hA5;
        if (a == 8'h02) return 8'h7E;
        if (a == 8'h03) return 8'hFF;
        return a ^ 8'h5A;
    endfunction

    // Drive one cycle of stimulus, queue its expected result, check after the edge.
    task automatic apply(input logic r, input logic e, input logic [7:0] a,
                         input logic [7:0] ed, input logic ev, input string name);
        exp_t x;
        @(negedge clk);
        rst  = r;
        en   = e;
        addr = a;
        sb.push_back('{d: ed, v: ev});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            x = sb.pop_front();
            total++;
            if (data !== x.d || valid !== x.v) begin
                bad++;
                $display("FAIL %s addr=%02h: got data=%02h valid=%b, want data=%02h valid=%b",
                         name, a, data, valid, x.d, x.v);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] held;

        rst  = 1'b1;
        en   = 1'b0;
        addr = 8'h00;

        vecs[0]  = '{1'b1, 1'b1, 8'h01, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 8'h01, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h00, 8'h3C, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 8'h01, 8'hA5, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 8'h02, 8'h7E, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 8'h03, 8'hFF, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 8'h04, 8'h5E, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 8'h80, 8'hDA, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 8'hFF, 8'hA5, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 8'h10, 8'hA5, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'h03, 8'hFF, 1'b1};

        for (int i = 0; i < 11; i++)
            apply(vecs[i].r, vecs[i].e, vecs[i].a, vecs[i].exp_d, vecs[i].exp_v, "vector");

        // Idle address sweep must not disturb the last word.
        for (int a = 8'h10; a <= 8'h20; a++)
            apply(1'b0, 1'b0, 8'(a), 8'hFF, 1'b0, "hold");

        // Reset on the edge that samples 0x02 discards that read.
        apply(1'b0, 1'b1, 8'h00, 8'h3C, 1'b1, "stream");
        apply(1'b0, 1'b1, 8'h01, 8'hA5, 1'b1, "stream");
        apply(1'b1, 1'b1, 8'h02, 8'h00, 1'b0, "mid_reset");
        apply(1'b0, 1'b1, 8'h03, 8'hFF, 1'b1, "resume");
        apply(1'b0, 1'b1, 8'h04, 8'h5E, 1'b1, "resume");

        // Back-to-back sweep of every address.
        for (int a = 0; a < 256; a++)
            apply(1'b0, 1'b1, 8'(a), ref_rom(8'(a)), 1'b1, "sweep");

        // Idle after sweep keeps the last word (0xFF -> 0xA5), valid drops.
        held = ref_rom(8'hFF);
        apply(1'b0, 1'b0, 8'h00, held, 1'b0, "post_sweep_idle");

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
